// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: serves latched requests on each YELLOW->RED vehicle transition.
// Optional countdown output during flashing clearance is enabled by defining PED_COUNTDOWN_EN.
module ped_signal_ctrl #(
  parameter int unsigned WALK_CYCLES  = 4,
  parameter int unsigned FLASH_CYCLES = 6,
  parameter int unsigned FLASH_DIV    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [0:2] light,
  input  logic       ped_button,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_wait,
  output logic       light_err,
  output logic [3:0] countdown
);

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD   = 4'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WALK  = 3'd2,
    S_FLASH = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [0:2] light_prev_q, light_prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] div_q, div_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic       ped_wait_q, ped_wait_d;
  logic       light_err_q, light_err_d;
  logic       legal;
  logic       red_entry;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    ped_wait_d   = ped_wait_q;
    light_prev_d = light;

    legal     = (light == L_RED) || (light == L_GREEN) || (light == L_YELLOW);
    red_entry = (light_prev_q == L_YELLOW) && (light == L_RED);

    if (!legal) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (ped_button) ped_wait_d = 1'b1;
          // a press sampled together with red_entry is served immediately
          if ((ped_button || ped_wait_q) && red_entry) begin
            state_d    = S_WALK;
            ped_wait_d = 1'b0;
            cnt_d      = WALK_LOAD;
          end else if (ped_button) begin
            state_d = S_WAIT;
          end
        end
        S_WALK: begin
          if (cnt_q == 8'd0 || light != L_RED) begin
            state_d = S_FLASH;
            cnt_d   = FLASH_LOAD;
            div_d   = DIV_LOAD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_FLASH: begin
          if (ped_button) ped_wait_d = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = (ped_wait_q || ped_button) ? S_WAIT : S_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
            div_d = (div_q == 4'd0) ? DIV_LOAD : div_q - 4'd1;
          end
        end
        S_ERR:   state_d = ped_wait_q ? S_WAIT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    walk_d      = (state_d == S_WALK);
    light_err_d = (state_d == S_ERR);
    if (state_d == S_FLASH) begin
      if (state_q != S_FLASH)  dont_walk_d = 1'b1;
      else if (div_q == 4'd0)  dont_walk_d = ~dont_walk_q;
      else                     dont_walk_d = dont_walk_q;
    end else begin
      dont_walk_d = ~walk_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      light_prev_q <= L_RED;
      cnt_q        <= 8'd0;
      div_q        <= 4'd0;
      walk_q       <= 1'b0;
      dont_walk_q  <= 1'b1;
      ped_wait_q   <= 1'b0;
      light_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      light_prev_q <= light_prev_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      walk_q       <= walk_d;
      dont_walk_q  <= dont_walk_d;
      ped_wait_q   <= ped_wait_d;
      light_err_q  <= light_err_d;
    end
  end

  assign walk      = walk_q;
  assign dont_walk = dont_walk_q;
  assign ped_wait  = ped_wait_q;
  assign light_err = light_err_q;

`ifdef PED_COUNTDOWN_EN
  logic [3:0] countdown_q, countdown_d;

  always_comb begin
    if (state_d != S_FLASH)      countdown_d = 4'd0;
    else if (state_q != S_FLASH) countdown_d = 4'(FLASH_CYCLES);
    else                         countdown_d = countdown_q - 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) countdown_q <= 4'd0;
    else          countdown_q <= countdown_d;
  end

  assign countdown = countdown_q;
`else
  assign countdown = 4'd0;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Randomized bench for ped_signal_ctrl against a phase-counting reference model.
module tb_ped_signal_ctrl;
  localparam int WC = 4;
  localparam int FC = 6;
  localparam int FD = 1;

  localparam logic [0:2] R = 3'b100;
  localparam logic [0:2] G = 3'b010;
  localparam logic [0:2] Y = 3'b001;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [0:2] light;
  logic       ped_button;
  logic       walk, dont_walk, ped_wait, light_err;
  logic [3:0] countdown;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: walk_left > 0 means WALK, flash_idx >= 0 means FLASH
  int         m_walk_left;
  int         m_flash_idx;
  bit         m_err;
  bit         m_wait;
  logic [0:2] m_prev;

  ped_signal_ctrl #(.WALK_CYCLES(WC), .FLASH_CYCLES(FC), .FLASH_DIV(FD)) dut (
    .clock(clock), .reset_n(reset_n), .light(light), .ped_button(ped_button),
    .walk(walk), .dont_walk(dont_walk), .ped_wait(ped_wait),
    .light_err(light_err), .countdown(countdown)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_walk_left = 0;
    m_flash_idx = -1;
    m_err       = 1'b0;
    m_wait      = 1'b0;
    m_prev      = R;
  endtask

  task automatic model_step(input logic [0:2] l, input bit b);
    bit legal, re;
    legal = (l == R) || (l == G) || (l == Y);
    re    = (m_prev == Y) && (l == R);
    if (!legal) begin
      m_err       = 1'b1;
      m_walk_left = 0;
      m_flash_idx = -1;
    end else if (m_err) begin
      m_err = 1'b0;
    end else if (m_walk_left > 0) begin
      if (m_walk_left == 1 || l != R) begin
        m_walk_left = 0;
        m_flash_idx = 0;
      end else begin
        m_walk_left--;
      end
    end else if (m_flash_idx >= 0) begin
      if (b) m_wait = 1'b1;
      if (m_flash_idx == FC - 1) m_flash_idx = -1;
      else m_flash_idx++;
    end else begin
      if (b) m_wait = 1'b1;
      if (m_wait && re) begin
        m_wait      = 1'b0;
        m_walk_left = WC;
      end
    end
    m_prev = l;
  endtask

  task automatic compare_all();
    bit e_walk, e_dw;
    int e_cd;
    e_walk = (m_walk_left > 0);
    if (m_flash_idx >= 0) e_dw = ((m_flash_idx / FD) % 2) == 0;
    else e_dw = !e_walk;
`ifdef PED_COUNTDOWN_EN
    e_cd = (m_flash_idx >= 0) ? FC - m_flash_idx : 0;
`else
    e_cd = 0;
`endif
    chk("walk",      8'(walk),      8'(e_walk));
    chk("dont_walk", 8'(dont_walk), 8'(e_dw));
    chk("ped_wait",  8'(ped_wait),  8'(m_wait));
    chk("light_err", 8'(light_err), 8'(m_err));
    chk("countdown", 8'(countdown), 8'(e_cd));
    chk("exclusive", 8'(walk & dont_walk), 8'd0);
  endtask

  task automatic cyc(input logic [0:2] l, input bit b);
    light      = l;
    ped_button = b;
    @(posedge clock);
    #1;
    model_step(l, b);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    compare_all();
  endtask

  initial begin
    logic [0:2] bad;
    int r;
    reset_n    = 1'b0;
    light      = R;
    ped_button = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // no request: lamps stay steady
    cyc(G, 0); cyc(Y, 0);
    for (int i = 0; i < 6; i++) cyc(R, 0);

    // single request, full walk and flash
    cyc(G, 1); cyc(Y, 0);
    for (int i = 0; i < 12; i++) cyc(R, 0);

    // fast upstream phases cut WALK short, FLASH still full length
    cyc(G, 1); cyc(Y, 0); cyc(R, 0);
    cyc(G, 0); cyc(Y, 0); cyc(R, 0);
    cyc(G, 0); cyc(Y, 0); cyc(R, 0); cyc(R, 0); cyc(R, 0);

    // illegal code while waiting, then recovery
    cyc(G, 1); cyc(3'b110, 0); cyc(G, 0); cyc(Y, 0);
    for (int i = 0; i < 12; i++) cyc(R, 0);

    // reset on the second WALK clock
    cyc(G, 1); cyc(Y, 0); cyc(R, 0); cyc(R, 0);
    #2;
    do_reset();
    cyc(R, 0); cyc(R, 0);

    // button held through WALK and FLASH gives a second WALK
    cyc(G, 1); cyc(Y, 1);
    for (int i = 0; i < 11; i++) cyc(R, 1);
    cyc(Y, 0);
    for (int i = 0; i < 12; i++) cyc(R, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
      r = $urandom_range(0, 39);
      if (r == 0) begin
        bad = 3'($urandom_range(0, 7));
        if (bad == R || bad == G || bad == Y) bad = 3'b111;
        cyc(bad, $urandom_range(0, 3) == 0);
      end else if (r < 22) cyc(R, $urandom_range(0, 5) == 0);
      else if (r < 32)     cyc(Y, $urandom_range(0, 5) == 0);
      else                 cyc(G, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
